// File: rtl/instr_fetch_unit_if.sv
// Memory-side request/grant/response bus of the instruction fetch unit.
// master: fetch unit (issues requests), slave: instruction memory.
interface instr_fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata,
    input  mem_err
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata,
    output mem_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: tagged word buffer in front of a variable-latency
// instruction memory, one request outstanding at a time.
// Build option IFU_PREFETCH_EN: two entries with LRU victim selection and
// next-word prefetch on a hit. Without it: a single entry, demand fetch only.
//
// state | meaning
// IDLE  | evaluate pc against the buffer, launch a demand miss (or prefetch)
// REQ   | mem_req held with stable mem_addr until mem_gnt
// WAIT  | request granted, waiting for mem_rvalid to fill (or discard)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_NOP = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc,
  input  logic               flush,
  output logic [31:0]        instruction_code,
  output logic               instr_valid,
  output logic               fetch_stall,
  output logic               fetch_fault,
  instr_fetch_unit_if.master mem
);

`ifdef IFU_PREFETCH_EN
  localparam int ENTRIES = 2;
`else
  localparam int ENTRIES = 1;
`endif

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t              state;
  logic                discard;
  logic [ENTRIES-1:0]  ent_valid;
  logic [ENTRIES-1:0]  ent_err;
  logic [29:0]         ent_tag  [ENTRIES];
  logic [31:0]         ent_data [ENTRIES];

  logic                aligned;
  logic                hit;
  logic                hit_err;
  logic [31:0]         hit_data;
  logic                fill_en;
  logic [ENTRIES-1:0]  victim_sel;

  assign aligned = (pc[1:0] == 2'b00);

  // Tag lookup of the current pc; at most one entry can hold a given tag.
  always_comb begin
    hit      = 1'b0;
    hit_err  = 1'b0;
    hit_data = RESET_NOP;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ent_valid[i] && (ent_tag[i] == pc[31:2])) begin
        hit      = 1'b1;
        hit_err  = ent_err[i];
        hit_data = ent_data[i];
      end
    end
  end

  // Core-facing outputs are combinational so a hit costs no cycle; held quiet in reset.
  always_comb begin
    instr_valid      = rst & aligned & hit & ~hit_err;
    fetch_fault      = rst & (~aligned | (hit & hit_err));
    fetch_stall      = ~instr_valid & ~fetch_fault;
    instruction_code = instr_valid ? hit_data : RESET_NOP;
  end

  // A response is written only if no flush hit it (earlier via discard, or now).
  assign fill_en = (state == WAIT) && mem.mem_rvalid && !discard && !flush;

`ifdef IFU_PREFETCH_EN
  logic [29:0] next_tag;
  logic        next_hit;
  logic        hit_idx;
  logic        lru;
  logic        victim;

  // Wraps naturally at the top of the address space.
  assign next_tag = pc[31:2] + 30'd1;

  // Lookup of pc+4 and the index of the entry currently hit by pc.
  always_comb begin
    next_hit = 1'b0;
    hit_idx  = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ent_valid[i] && (ent_tag[i] == next_tag)) next_hit = 1'b1;
      if (ent_valid[i] && (ent_tag[i] == pc[31:2])) hit_idx = 1'(i);
    end
  end

  // Never evict the word the core is sitting on; otherwise prefer a free slot, then LRU.
  always_comb begin
    victim = lru;
    if (ent_valid[0] && (ent_tag[0] == pc[31:2]))      victim = 1'b1;
    else if (ent_valid[1] && (ent_tag[1] == pc[31:2])) victim = 1'b0;
    else if (!ent_valid[0])                            victim = 1'b0;
    else if (!ent_valid[1])                            victim = 1'b1;
    victim_sel = victim ? 2'b10 : 2'b01;
  end

  // lru points at the entry that was not hit most recently.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lru <= 1'b0;
    end else if (aligned && hit) begin
      lru <= ~hit_idx;
    end
  end
`else
  assign victim_sel = 1'b1;
`endif

  // Buffer storage: flush and reset clear valid bits, responses fill the victim.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ent_valid <= '0;
    end else if (flush) begin
      ent_valid <= '0;
    end else if (fill_en) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (victim_sel[i]) begin
          ent_valid[i] <= 1'b1;
          ent_err[i]   <= mem.mem_err;
          ent_tag[i]   <= mem.mem_addr[31:2];
          ent_data[i]  <= mem.mem_rdata;
        end
      end
    end
  end

  // Request FSM with registered mem_req/mem_addr; mem_addr doubles as the fill tag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      discard      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          discard <= 1'b0;
          if (aligned && !hit) begin
            mem.mem_addr <= {pc[31:2], 2'b00};
            mem.mem_req  <= 1'b1;
            state        <= REQ;
          end
`ifdef IFU_PREFETCH_EN
          else if (aligned && !next_hit) begin
            mem.mem_addr <= {next_tag, 2'b00};
            mem.mem_req  <= 1'b1;
            state        <= REQ;
          end
`endif
        end
        REQ: begin
          if (flush) discard <= 1'b1;
          if (mem.mem_gnt) begin
            mem.mem_req <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (mem.mem_rvalid) begin
            discard <= 1'b0;
            state   <= IDLE;
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        default: begin
          mem.mem_req <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: behavioural memory with programmable grant
// and response delay, request-address scoreboard, per-scenario tasks.
module tb_instr_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [31:0] instruction_code;
  logic        instr_valid;
  logic        fetch_stall;
  logic        fetch_fault;

  instr_fetch_unit_if mem_bus ();

  logic        m_gnt = 1'b0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  logic        m_err = 1'b0;
  assign mem_bus.mem_gnt    = m_gnt;
  assign mem_bus.mem_rvalid = m_rvalid;
  assign mem_bus.mem_rdata  = m_rdata;
  assign mem_bus.mem_err    = m_err;

  instr_fetch_unit #(.RESET_NOP(NOP)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc               (pc),
    .flush            (flush),
    .instruction_code (instruction_code),
    .instr_valid      (instr_valid),
    .fetch_stall      (fetch_stall),
    .fetch_fault      (fetch_fault),
    .mem              (mem_bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int          gnt_delay = 0;
  int          rsp_delay = 0;
  logic [31:0] err_addr  = 32'hFFFF_FFFF;
  logic [31:0] exp_q[$];
  logic [31:0] granted_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0] ^ 16'hC3A5, a[15:2], 2'b11};
  endfunction

  // Memory model: decides grant/response at the falling edge for the next rising edge.
  bit          pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          wcnt = 0;
  int          rcnt = 0;
  always @(negedge clk) begin
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; m_err = 1'b0;
    if (!rst) begin
      pend = 1'b0; wcnt = 0; rcnt = 0;
    end else if (pend) begin
      if (rcnt >= rsp_delay) begin
        m_rvalid = 1'b1;
        m_rdata  = mem_word(pend_addr);
        m_err    = (pend_addr == err_addr);
        pend     = 1'b0;
      end else begin
        rcnt++;
      end
    end else if (mem_bus.mem_req) begin
      if (wcnt >= gnt_delay) begin
        m_gnt = 1'b1;
        granted_q.push_back(mem_bus.mem_addr);
        pend = 1'b1; pend_addr = mem_bus.mem_addr; rcnt = 0; wcnt = 0;
      end else begin
        wcnt++;
      end
    end
  end

  task automatic next_cycle(input logic [31:0] p);
    @(posedge clk); #1;
    pc = p;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pc = 32'h0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      total++; if (mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req: got %b want 0", mem_bus.mem_req); end
      total++; if (mem_bus.mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_bus.mem_addr); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
      total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL rst_fault: got %b want 0", fetch_fault); end
      total++; if (instruction_code !== NOP) begin bad++; $display("FAIL rst_code: got %h want %h", instruction_code, NOP); end
    end
    rst = 1'b1;
  endtask

  task automatic test_cold_miss();
    exp_q.push_back(32'h0);
    #1;
    total++; if (mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL cold_c0_req: got %b want 0", mem_bus.mem_req); end
    total++; if (fetch_stall !== 1'b1) begin bad++; $display("FAIL cold_c0_stall: got %b want 1", fetch_stall); end
    next_cycle(32'h0);
    total++; if (mem_bus.mem_req !== 1'b1) begin bad++; $display("FAIL cold_c1_req: got %b want 1", mem_bus.mem_req); end
    total++; if (mem_bus.mem_addr !== 32'h0) begin bad++; $display("FAIL cold_c1_addr: got %h want 0", mem_bus.mem_addr); end
    next_cycle(32'h0);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL cold_c2_valid: got %b want 0", instr_valid); end
    next_cycle(32'h0);
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL cold_c3_valid: got %b want 1", instr_valid); end
    total++; if (instruction_code !== 32'h0050_0093) begin bad++; $display("FAIL cold_c3_code: got %h want 00500093", instruction_code); end
    total++; if (fetch_stall !== 1'b0) begin bad++; $display("FAIL cold_c3_stall: got %b want 0", fetch_stall); end
  endtask

  task automatic test_hold_hit();
    exp_q.push_back(32'h10);
    next_cycle(32'h10);
    for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) next_cycle(32'h10);
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL hold_fill_timeout: got %b want 1", instr_valid); end
    for (int i = 0; i < 4; i++) begin
      next_cycle(32'h10);
      total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL hold_valid: got %b want 1", instr_valid); end
      total++; if (instruction_code !== mem_word(32'h10)) begin bad++; $display("FAIL hold_code: got %h want %h", instruction_code, mem_word(32'h10)); end
      total++; if (mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL hold_no_req: got %b want 0", mem_bus.mem_req); end
    end
  endtask

  task automatic test_misaligned();
    next_cycle(32'h22);
    total++; if (fetch_fault !== 1'b1) begin bad++; $display("FAIL mis_fault: got %b want 1", fetch_fault); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL mis_valid: got %b want 0", instr_valid); end
    total++; if (fetch_stall !== 1'b0) begin bad++; $display("FAIL mis_stall: got %b want 0", fetch_stall); end
    total++; if (instruction_code !== NOP) begin bad++; $display("FAIL mis_code: got %h want %h", instruction_code, NOP); end
    for (int i = 0; i < 3; i++) begin
      next_cycle(32'h22);
      total++; if (mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL mis_no_req: got %b want 0", mem_bus.mem_req); end
    end
  endtask

  task automatic test_grant_delay();
    gnt_delay = 4;
    exp_q.push_back(32'h40);
    next_cycle(32'h40);
    for (int i = 0; i < 5; i++) begin
      next_cycle(32'h80);
      total++; if (mem_bus.mem_req !== 1'b1) begin bad++; $display("FAIL gd_req_held: got %b want 1", mem_bus.mem_req); end
      total++; if (mem_bus.mem_addr !== 32'h40) begin bad++; $display("FAIL gd_addr_stable: got %h want 00000040", mem_bus.mem_addr); end
    end
    gnt_delay = 0;
    exp_q.push_back(32'h80);
    for (int i = 0; i < 30 && instr_valid !== 1'b1; i++) next_cycle(32'h80);
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL gd_second_timeout: got %b want 1", instr_valid); end
    total++; if (instruction_code !== mem_word(32'h80)) begin bad++; $display("FAIL gd_second_code: got %h want %h", instruction_code, mem_word(32'h80)); end
  endtask

  task automatic test_flush();
    rsp_delay = 3;
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h40);
    next_cycle(32'h40);
    next_cycle(32'h40);
    total++; if (mem_bus.mem_req !== 1'b1) begin bad++; $display("FAIL fl_req: got %b want 1", mem_bus.mem_req); end
    next_cycle(32'h40); flush = 1'b1;
    next_cycle(32'h40); flush = 1'b0;
    next_cycle(32'h40);
    next_cycle(32'h40);
    next_cycle(32'h40);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL fl_discard: got %b want 0", instr_valid); end
    next_cycle(32'h40);
    total++; if (mem_bus.mem_req !== 1'b1) begin bad++; $display("FAIL fl_refetch_req: got %b want 1", mem_bus.mem_req); end
    total++; if (mem_bus.mem_addr !== 32'h40) begin bad++; $display("FAIL fl_refetch_addr: got %h want 00000040", mem_bus.mem_addr); end
    rsp_delay = 0;
    for (int i = 0; i < 30 && instr_valid !== 1'b1; i++) next_cycle(32'h40);
    total++; if (instruction_code !== mem_word(32'h40)) begin bad++; $display("FAIL fl_refill_code: got %h want %h", instruction_code, mem_word(32'h40)); end
    // flush coinciding with the response itself
    exp_q.push_back(32'h48);
    exp_q.push_back(32'h48);
    next_cycle(32'h48);
    next_cycle(32'h48);
    next_cycle(32'h48); flush = 1'b1;
    next_cycle(32'h48); flush = 1'b0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL fl_same_cycle_discard: got %b want 0", instr_valid); end
    next_cycle(32'h48);
    total++; if (mem_bus.mem_addr !== 32'h48 || mem_bus.mem_req !== 1'b1) begin bad++; $display("FAIL fl_same_cycle_refetch: got req=%b addr=%h want req=1 addr=00000048", mem_bus.mem_req, mem_bus.mem_addr); end
    for (int i = 0; i < 30 && instr_valid !== 1'b1; i++) next_cycle(32'h48);
    total++; if (instruction_code !== mem_word(32'h48)) begin bad++; $display("FAIL fl_same_cycle_code: got %h want %h", instruction_code, mem_word(32'h48)); end
  endtask

  task automatic test_mem_err();
    err_addr = 32'h60;
    exp_q.push_back(32'h60);
    next_cycle(32'h60);
    for (int i = 0; i < 30 && fetch_fault !== 1'b1; i++) next_cycle(32'h60);
    total++; if (fetch_fault !== 1'b1) begin bad++; $display("FAIL err_fault: got %b want 1", fetch_fault); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL err_valid: got %b want 0", instr_valid); end
    total++; if (fetch_stall !== 1'b0) begin bad++; $display("FAIL err_stall: got %b want 0", fetch_stall); end
    for (int i = 0; i < 2; i++) begin
      next_cycle(32'h60);
      total++; if (mem_bus.mem_req !== 1'b0 || fetch_fault !== 1'b1) begin bad++; $display("FAIL err_sticky: got req=%b fault=%b want req=0 fault=1", mem_bus.mem_req, fetch_fault); end
    end
    exp_q.push_back(32'h64);
    next_cycle(32'h64);
    total++; if (fetch_fault !== 1'b0 || fetch_stall !== 1'b1) begin bad++; $display("FAIL err_next_word: got fault=%b stall=%b want fault=0 stall=1", fetch_fault, fetch_stall); end
    for (int i = 0; i < 30 && instr_valid !== 1'b1; i++) next_cycle(32'h64);
    total++; if (instruction_code !== mem_word(32'h64)) begin bad++; $display("FAIL err_next_code: got %h want %h", instruction_code, mem_word(32'h64)); end
  endtask

  task automatic test_prefetch();
    int stalls;
    for (int i = 0; i < 8; i++) next_cycle(32'h2);
    flush = 1'b1;
    next_cycle(32'h2);
    flush = 1'b0;
    next_cycle(32'h2);
    exp_q.delete();
    granted_q.delete();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    stalls = 0;
    next_cycle(32'h0);
    for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) begin stalls++; next_cycle(32'h0); end
    total++; if (stalls !== 3) begin bad++; $display("FAIL pf_first_stall: got %0d want 3", stalls); end
    repeat (3) next_cycle(32'h0);
    next_cycle(32'h4);
    total++; if (instr_valid !== 1'b1 || instruction_code !== mem_word(32'h4)) begin bad++; $display("FAIL pf_word4: got valid=%b code=%h want 1 %h", instr_valid, instruction_code, mem_word(32'h4)); end
    repeat (3) next_cycle(32'h4);
    next_cycle(32'h8);
    total++; if (instr_valid !== 1'b1 || instruction_code !== mem_word(32'h8)) begin bad++; $display("FAIL pf_word8: got valid=%b code=%h want 1 %h", instr_valid, instruction_code, mem_word(32'h8)); end
    repeat (3) next_cycle(32'h8);
    next_cycle(32'hFFFF_FFFC);
    for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) next_cycle(32'hFFFF_FFFC);
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL pf_top_timeout: got %b want 1", instr_valid); end
    next_cycle(32'hFFFF_FFFC);
    total++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 32'h0) begin bad++; $display("FAIL pf_wrap_addr: got req=%b addr=%h want req=1 addr=00000000", mem_bus.mem_req, mem_bus.mem_addr); end
    repeat (4) next_cycle(32'hFFFF_FFFC);
  endtask

  task automatic test_request_log();
    logic [31:0] e;
    logic [31:0] g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (granted_q.size() == 0) begin
        bad++; $display("FAIL req_log_missing: got none want %h", e);
      end else begin
        g = granted_q.pop_front();
        if (g !== e) begin bad++; $display("FAIL req_log_addr: got %h want %h", g, e); end
      end
    end
    total++; if (granted_q.size() != 0) begin bad++; $display("FAIL req_log_extra: got %0d extra requests want 0", granted_q.size()); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
`ifdef IFU_PREFETCH_EN
    test_prefetch();
`else
    test_hold_hit();
    test_misaligned();
    test_grant_delay();
    test_flush();
    test_mem_err();
`endif
    test_request_log();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
